// File: rtl/pucch_ncs_hop.sv
// PUCCH cyclic-shift hopping engine: arms the c-sequence generator for one slot,
// packs 8 Gold-sequence bits per OFDM symbol into n_cs and hands each value
// downstream over a valid/ready handshake.
module pucch_ncs_hop #(
  parameter int nGenBit = 2,
  parameter int N_SYMB  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [9:0]         i_nid,
  input  logic [4:0]         i_slot,
  output logic               o_cs_start,
  output logic [30:0]        o_cs_init,
  output logic [15:0]        o_cs_threshold,
  output logic               o_cs_get,
  input  logic [nGenBit-1:0] i_cs_bit,
  input  logic               i_cs_valid,
  input  logic               i_cs_done,
  output logic [7:0]         o_ncs,
  output logic [3:0]         o_l,
  output logic               o_ncs_valid,
  input  logic               i_ncs_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam int unsigned WORDS = 8 / nGenBit;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_COLLECT = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;
  localparam logic [2:0] S_FIN     = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [3:0]  l_q, l_d;
  logic [7:0]  ncs_q, ncs_d;
  logic [3:0]  lout_q, lout_d;
  logic        ncs_valid_q, ncs_valid_d;
  logic        cs_start_q, cs_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [30:0] init_q, init_d;
  logic [15:0] thr_q, thr_d;

  logic [7:0]  acc_nxt;
  logic [3:0]  shamt;

  // Word bit k lands at accumulator position wcnt*nGenBit + k
  always_comb begin
    shamt   = wcnt_q * 4'(nGenBit);
    acc_nxt = acc_q | (8'(i_cs_bit) << shamt);
  end

  // Consume a generator word only while in COLLECT and the word is present
  assign o_cs_get = (state_q == S_COLLECT) & i_cs_valid;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      wcnt_q      <= '0;
      l_q         <= '0;
      ncs_q       <= '0;
      lout_q      <= '0;
      ncs_valid_q <= 1'b0;
      cs_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      init_q      <= '0;
      thr_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      wcnt_q      <= wcnt_d;
      l_q         <= l_d;
      ncs_q       <= ncs_d;
      lout_q      <= lout_d;
      ncs_valid_q <= ncs_valid_d;
      cs_start_q  <= cs_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      init_q      <= init_d;
      thr_q       <= thr_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    wcnt_d      = wcnt_q;
    l_d         = l_q;
    ncs_d       = ncs_q;
    lout_d      = lout_q;
    ncs_valid_d = ncs_valid_q;
    err_d       = err_q;
    init_d      = init_q;
    thr_d       = thr_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          init_d  = {21'd0, i_nid};
          thr_d   = 16'(N_SYMB) * 16'(i_slot);
          err_d   = 1'b0;
          wcnt_d  = '0;
          l_d     = '0;
          acc_d   = '0;
          state_d = S_ARM;
        end
      end
      S_ARM: state_d = S_WAIT;
      S_WAIT: begin
        if (i_cs_done) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (i_cs_valid) begin
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (i_cs_done) begin
          // generator ran dry: the partial byte is dropped
          err_d   = 1'b1;
          done_d  = 1'b1;
          acc_d   = '0;
          wcnt_d  = '0;
          state_d = S_IDLE;
        end else if (i_cs_valid) begin
          if (wcnt_q == 4'(WORDS - 1)) begin
            ncs_d       = acc_nxt;
            lout_d      = l_q;
            ncs_valid_d = 1'b1;
            acc_d       = '0;
            wcnt_d      = '0;
            state_d     = S_HOLD;
          end else begin
            acc_d  = acc_nxt;
            wcnt_d = wcnt_q + 4'd1;
          end
        end
      end
      S_HOLD: begin
        if (ncs_valid_q && i_ncs_ready) begin
          ncs_valid_d = 1'b0;
          if (l_q == 4'(N_SYMB - 1)) begin
            state_d = S_FIN;
          end else begin
            l_d     = l_q + 4'd1;
            state_d = S_COLLECT;
          end
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cs_start_d = (state_d == S_ARM);
    busy_d     = (state_d != S_IDLE);
  end

  assign o_cs_start     = cs_start_q;
  assign o_cs_init      = init_q;
  assign o_cs_threshold = thr_q;
  assign o_ncs          = ncs_q;
  assign o_l            = lout_q;
  assign o_ncs_valid    = ncs_valid_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_pucch_ncs_hop.sv
// Bench for pucch_ncs_hop: four instances (nGenBit = 2, 1, 4, 8) each fed by a
// behavioural Gold-sequence generator; expected n_cs values come from a
// bit-serial reference of the c-sequence.
module tb_pucch_ncs_hop;

  localparam int N_SYMB = 14;
  localparam int NBITS  = 8 * N_SYMB;

  typedef struct packed {
    logic [3:0] l;
    logic [7:0] v;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start     [4];
  logic        ready     [4];
  logic [9:0]  nid;
  logic [4:0]  slot;
  logic        cs_start  [4];
  logic [30:0] cs_init   [4];
  logic [15:0] cs_thr    [4];
  logic        cs_get    [4];
  logic [7:0]  word      [4];
  logic        cs_valid  [4];
  logic        cs_done   [4];
  logic [7:0]  ncs       [4];
  logic [3:0]  lo        [4];
  logic        ncs_valid [4];
  logic        busy      [4];
  logic        done      [4];
  logic        err       [4];

  bit gold_arr [0:127];
  int ptr      [4];
  int nwords   [4];
  bit active   [4];
  bit gap_en   [4];
  int early_words [4];

  ent_t exp_q[$];
  ent_t obs_q[$];

  int tests = 0;
  int fails = 0;
  int n_hs, n_done, n_words, n_cs_start;
  int stab_bad, get_bad, hold_get_bad, busy_bad, spacing_bad;
  bit timeout;
  logic err_first, err_at_done;

  function automatic int wid(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      2:       return 4;
      default: return 8;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gen_u
    localparam int W = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
    pucch_ncs_hop #(.nGenBit(W), .N_SYMB(N_SYMB)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .i_start        (start[g]),
      .i_nid          (nid),
      .i_slot         (slot),
      .o_cs_start     (cs_start[g]),
      .o_cs_init      (cs_init[g]),
      .o_cs_threshold (cs_thr[g]),
      .o_cs_get       (cs_get[g]),
      .i_cs_bit       (word[g][W-1:0]),
      .i_cs_valid     (cs_valid[g]),
      .i_cs_done      (cs_done[g]),
      .o_ncs          (ncs[g]),
      .o_l            (lo[g]),
      .o_ncs_valid    (ncs_valid[g]),
      .i_ncs_ready    (ready[g]),
      .o_busy         (busy[g]),
      .o_done         (done[g]),
      .o_err          (err[g])
    );
  end

  // Generator word presented at the current read pointer, earliest bit in bit 0
  always_comb begin
    for (int g = 0; g < 4; g++) begin
      word[g] = 8'd0;
      for (int k = 0; k < 8; k++)
        if (k < wid(g)) word[g][k] = gold_arr[(ptr[g] + k) % 128];
    end
  end

  // Behavioural c-sequence generator per instance
  always @(posedge clk or posedge rst) begin
    int n, p;
    for (int g = 0; g < 4; g++) begin
      if (rst) begin
        active[g] <= 1'b0; ptr[g] <= 0; nwords[g] <= 0;
        cs_valid[g] <= 1'b0; cs_done[g] <= 1'b0;
      end else if (cs_start[g]) begin
        active[g] <= 1'b1; ptr[g] <= 0; nwords[g] <= 0;
        cs_valid[g] <= 1'b0; cs_done[g] <= 1'b0;
      end else if (active[g]) begin
        n = nwords[g];
        p = ptr[g];
        if (cs_get[g] && cs_valid[g]) begin
          n = n + 1;
          p = p + wid(g);
        end
        nwords[g] <= n;
        ptr[g]    <= p;
        if (early_words[g] != 0 && n >= early_words[g]) begin
          cs_done[g] <= 1'b1; cs_valid[g] <= 1'b0; active[g] <= 1'b0;
        end else if (p >= NBITS) begin
          cs_valid[g] <= 1'b0;
        end else begin
          cs_valid[g] <= gap_en[g] ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end
    end
  end

  // Bit-serial Gold sequence: fills gold_arr with c(112*slot + i), i = 0..111
  task automatic push_expected();
    logic [30:0] x1, x2;
    logic [7:0]  v;
    ent_t        e;
    int          skip;
    x1   = 31'd1;
    x2   = {21'd0, nid};
    skip = 1600 + NBITS * int'(slot);
    for (int i = 0; i < skip; i++) begin
      x1 = {x1[3] ^ x1[0], x1[30:1]};
      x2 = {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[30:1]};
    end
    for (int i = 0; i < NBITS; i++) begin
      gold_arr[i] = x1[0] ^ x2[0];
      x1 = {x1[3] ^ x1[0], x1[30:1]};
      x2 = {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[30:1]};
    end
    for (int l = 0; l < N_SYMB; l++) begin
      v = 8'd0;
      for (int m = 0; m < 8; m++) v[m] = gold_arr[8 * l + m];
      e.l = 4'(l);
      e.v = v;
      exp_q.push_back(e);
    end
  endtask

  // Issue one request on instance g and record what the DUT does (no checking here)
  task automatic run_slot(input int g, input bit rand_ready, input int stop_after,
                          input int extra_start_at, input int max_cycles);
    bit         stall;
    logic [7:0] pv;
    logic [3:0] pl;
    int         last_hs;
    int         it;
    ent_t       e;
    obs_q.delete();
    n_hs = 0; n_done = 0; n_words = 0; n_cs_start = 0;
    stab_bad = 0; get_bad = 0; hold_get_bad = 0; busy_bad = 0; spacing_bad = 0;
    timeout = 1'b0; err_at_done = 1'bx; err_first = 1'bx;
    stall = 1'b0; pv = '0; pl = '0; last_hs = -1;
    start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
    for (it = 0; it < max_cycles; it++) begin
      if (it == 0) err_first = err[g];
      if (cs_start[g]) n_cs_start++;
      start[g] = (it == extra_start_at);
      if (done[g]) begin
        n_done++;
        err_at_done = err[g];
        if (busy[g]) busy_bad++;
        break;
      end
      if (cs_get[g] && !cs_valid[g]) get_bad++;
      if (cs_get[g] && ncs_valid[g]) hold_get_bad++;
      if (cs_get[g] && cs_valid[g]) n_words++;
      if (stall && (!ncs_valid[g] || ncs[g] !== pv || lo[g] !== pl)) stab_bad++;
      ready[g] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stall = ncs_valid[g] && !ready[g];
      pv = ncs[g];
      pl = lo[g];
      if (ncs_valid[g] && ready[g]) begin
        e.l = lo[g];
        e.v = ncs[g];
        obs_q.push_back(e);
        n_hs++;
        if (last_hs >= 0 && (it - last_hs) != 8 / wid(g) + 1) spacing_bad++;
        last_hs = it;
        if (n_hs == stop_after) begin
          @(posedge clk); #1;
          start[g] = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
    end
    start[g] = 1'b0;
    if (it >= max_cycles) timeout = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done[g]) n_done++;
    end
  endtask

  task automatic test_reset();
    logic [64:0] snap;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      snap = {cs_start[g], cs_init[g], cs_thr[g], cs_get[g], ncs[g], lo[g],
              ncs_valid[g], busy[g], done[g], err[g]};
      tests++;
      if (snap !== 65'd0) begin
        fails++;
        $display("FAIL reset_outputs[w=%0d]: got %h, required 0", wid(g), snap);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    ent_t e, o;
    nid = 10'd512; slot = 5'd3;
    exp_q.delete();
    push_expected();
    run_slot(0, 1'b0, -1, -1, 2000);
    tests++;
    if (cs_init[0] !== 31'd512) begin
      fails++; $display("FAIL nominal_cs_init: got %0d, required 512", cs_init[0]);
    end
    tests++;
    if (cs_thr[0] !== 16'd42) begin
      fails++; $display("FAIL nominal_threshold: got %0d, required 42", cs_thr[0]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL nominal_ncs l=%0d: no output, required %0d", e.l, e.v);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL nominal_ncs: got l=%0d ncs=%0d, required l=%0d ncs=%0d", o.l, o.v, e.l, e.v);
        end
      end
    end
    tests++;
    if (n_done !== 1 || err_at_done !== 1'b0) begin
      fails++; $display("FAIL nominal_done: pulses=%0d err=%b, required 1 and 0", n_done, err_at_done);
    end
    tests++;
    if (spacing_bad !== 0 || n_words !== 56) begin
      fails++; $display("FAIL nominal_throughput: bad_gaps=%0d words=%0d, required 0 and 56", spacing_bad, n_words);
    end
    tests++;
    if (busy_bad !== 0 || hold_get_bad !== 0 || timeout) begin
      fails++; $display("FAIL nominal_ctrl: busy_at_done=%0d get_in_hold=%0d timeout=%b, required 0 0 0", busy_bad, hold_get_bad, timeout);
    end
  endtask

  task automatic test_backpressure();
    ent_t e, o;
    int   bad;
    nid = 10'd512; slot = 5'd3;
    exp_q.delete();
    push_expected();
    run_slot(0, 1'b1, -1, -1, 4000);
    bad = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) bad++;
      else begin
        o = obs_q.pop_front();
        if (o !== e) bad++;
      end
    end
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL backpressure_seq: %0d wrong values, required 0", bad);
    end
    tests++;
    if (stab_bad !== 0) begin
      fails++; $display("FAIL backpressure_stable: %0d unstable stalls, required 0", stab_bad);
    end
    tests++;
    if (hold_get_bad !== 0 || n_words !== 56 || n_done !== 1) begin
      fails++; $display("FAIL backpressure_get: hold_gets=%0d words=%0d done=%0d, required 0 56 1", hold_get_bad, n_words, n_done);
    end
  endtask

  task automatic test_valid_gaps();
    ent_t e, o;
    int   bad;
    nid = 10'd512; slot = 5'd3;
    gap_en[0] = 1'b1;
    exp_q.delete();
    push_expected();
    run_slot(0, 1'b1, -1, -1, 4000);
    gap_en[0] = 1'b0;
    bad = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) bad++;
      else begin
        o = obs_q.pop_front();
        if (o !== e) bad++;
      end
    end
    tests++;
    if (bad !== 0 || n_done !== 1) begin
      fails++; $display("FAIL gaps_seq: %0d wrong values done=%0d, required 0 and 1", bad, n_done);
    end
    tests++;
    if (get_bad !== 0 || n_words !== 56) begin
      fails++; $display("FAIL gaps_get: get_without_valid=%0d words=%0d, required 0 and 56", get_bad, n_words);
    end
  endtask

  task automatic test_early_done();
    ent_t e, o;
    int   bad;
    nid = 10'd512; slot = 5'd3;
    early_words[0] = 20;
    exp_q.delete();
    push_expected();
    run_slot(0, 1'b0, -1, -1, 2000);
    early_words[0] = 0;
    bad = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) bad++;
    end
    tests++;
    if (n_hs !== 5 || bad !== 0) begin
      fails++; $display("FAIL early_handshakes: count=%0d wrong=%0d, required 5 and 0", n_hs, bad);
    end
    tests++;
    if (err_at_done !== 1'b1 || n_done !== 1) begin
      fails++; $display("FAIL early_err: err=%b done=%0d, required 1 and 1", err_at_done, n_done);
    end
    tests++;
    if (err[0] !== 1'b1) begin
      fails++; $display("FAIL early_sticky: err=%b, required 1", err[0]);
    end
    exp_q.delete();
    push_expected();
    run_slot(0, 1'b0, -1, -1, 2000);
    exp_q.delete();
    tests++;
    if (err_first !== 1'b0 || err_at_done !== 1'b0 || n_hs !== 14) begin
      fails++; $display("FAIL early_clear: err_after_start=%b err_at_done=%b hs=%0d, required 0 0 14", err_first, err_at_done, n_hs);
    end
  endtask

  task automatic test_reset_restart();
    ent_t        e, o;
    int          bad;
    logic [64:0] snap;
    nid = 10'd512; slot = 5'd3;
    exp_q.delete();
    push_expected();
    run_slot(0, 1'b0, 6, -1, 2000);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    snap = {cs_start[0], cs_init[0], cs_thr[0], cs_get[0], ncs[0], lo[0],
            ncs_valid[0], busy[0], done[0], err[0]};
    tests++;
    if (snap !== 65'd0) begin
      fails++; $display("FAIL midrun_reset: got %h, required 0", snap);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push_expected();
    run_slot(0, 1'b0, -1, 10, 2000);
    bad = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) bad++;
      else begin
        o = obs_q.pop_front();
        if (o !== e) bad++;
      end
    end
    tests++;
    if (bad !== 0 || n_done !== 1) begin
      fails++; $display("FAIL restart_seq: %0d wrong values done=%0d, required 0 and 1", bad, n_done);
    end
    tests++;
    if (n_cs_start !== 1) begin
      fails++; $display("FAIL busy_start_ignored: cs_start pulses=%0d, required 1", n_cs_start);
    end
  endtask

  task automatic test_param_sweep();
    ent_t e, o;
    int   bad;
    for (int g = 1; g < 4; g++) begin
      nid = 10'd512; slot = 5'd3;
      exp_q.delete();
      push_expected();
      run_slot(g, 1'b0, -1, -1, 2000);
      bad = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (obs_q.size() == 0) bad++;
        else begin
          o = obs_q.pop_front();
          if (o !== e) bad++;
        end
      end
      tests++;
      if (bad !== 0 || n_done !== 1 || err_at_done !== 1'b0) begin
        fails++; $display("FAIL sweep_seq[w=%0d]: wrong=%0d done=%0d err=%b, required 0 1 0", wid(g), bad, n_done, err_at_done);
      end
      tests++;
      if (spacing_bad !== 0 || n_words !== NBITS / wid(g)) begin
        fails++; $display("FAIL sweep_rate[w=%0d]: bad_gaps=%0d words=%0d, required 0 and %0d", wid(g), spacing_bad, n_words, NBITS / wid(g));
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    nid  = '0;
    slot = '0;
    for (int g = 0; g < 4; g++) begin
      start[g]       = 1'b0;
      ready[g]       = 1'b1;
      gap_en[g]      = 1'b0;
      early_words[g] = 0;
    end
    test_reset();
    test_nominal();
    test_backpressure();
    test_valid_gaps();
    test_early_done();
    test_reset_restart();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
